pipe_addsub: RTL
================

# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor and the successor to the fixed 16-bit ripple-carry adder. The carry chain is split into SEG-bit segments, with one register stage per segment, so WIDTH scales without lengthening the critical path. The block adds carry-in, subtract and borrow modes, a valid/ready handshake with backpressure, and registered status flags. It sits between operand producers and result consumers in the datapath and accepts one operation per clock when not stalled.

## Interface
- WIDTH, 16: operand/result width in bits. Must be a multiple of SEG.
- SEG, 4: bits resolved per pipeline stage. STAGES = WIDTH/SEG, with STAGES ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  operation select: 00 A+B; 01 A−B; 10 A+B+cin; 11 A−B−(~cin), i.e. subtract with borrow where cin=1 means no borrow.
- cin  in  1  carry/no-borrow input, used only for op=1x.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Effective operand B' = op[0] ? ~b : b.
- Effective carry-in c0:
  - op=00: 0
  - op=01: 1
  - op=10: cin
  - op=11: cin
- Stage k (k = 0..STAGES−1) adds slice [k·SEG +: SEG] of A and B' plus the carry registered by stage k−1 (c0 for stage 0). It registers the slice sum and the slice carry.
- Higher slices of A and B' travel through skew registers, so slice k enters stage k exactly k cycles after acceptance. Lower result slices are delayed so all slices align at the output.
- Flags are computed from the final aligned values:
  - cout = carry out of slice STAGES−1.
  - ovf = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]). A[W−1] and B'[W−1] are carried down the pipe.
  - zero = ~|sum.
- Each stage holds a valid bit. The pipeline moves as a whole: advance = !out_valid || out_ready.
- in_ready = advance, a combinational function of out_valid and out_ready only.
- A beat is accepted when in_valid && in_ready. When advance=0, every stage register, skew register and valid bit holds.
- Bubbles (in_valid=0 while advancing) propagate as valid=0 stages. Data in invalid stages is don't-care, but sum, cout, ovf and zero must hold their last values whenever out_valid=0.
- No reordering or dropping: results leave in acceptance order, one per accepted beat.
- STAGES=1 degenerates to one registered full-width adder. It still has the same handshake and flags.

## Timing
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES−1, and is held until out_ready=1.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 in the same cycle, and outputs are stable until the handshake completes.
- Simultaneous output handshake and input accept in one cycle is required and must lose nothing.
- Reset (asynchronous, any time including mid-stream):
  - All valid bits, sum, cout, ovf and zero clear to 0 immediately.
  - in_ready = 1 while rst is high.
  - In-flight beats are discarded.
  - The first accept is possible at the first clk edge after rst deasserts.
- No combinational path from a, b, op, cin or in_valid to any output. out_ready reaches in_ready combinationally only.

## Test plan
Scenarios use WIDTH=16 and SEG=4, so latency is 4.
- Reset: hold rst mid-stream with 3 beats in flight → out_valid=0, sum=0 and all flags 0 at once. After release, a new beat 0x0001+0x0001 yields sum=0x0002 four cycles later with no stale beats.
- Carry across segments: 0xFFFF+0x0001, op=00 → sum=0x0000, cout=1, zero=1, ovf=0. Also 0x7FFF+0x0001 → sum=0x8000, ovf=1, cout=0.
- Subtract and borrow:
  - 0x0005−0x0007, op=01 → sum=0xFFFE, cout=0.
  - 0x8000−0x0001 → sum=0x7FFF, ovf=1.
  - op=11 with cin=0: 0x0010−0x0001 → 0x000E.
  - op=10 with cin=1: 0x1234+0x1111 → 0x2346.
- Streaming: 20 back-to-back random beats with out_ready=1 → one result per cycle after 4 cycles, each matching the reference model in order.
- Backpressure: stream random beats while toggling out_ready with random 30% low → in_ready mirrors the stall, held outputs never change while stalled, and the count and order of results are exact.
- Bubbles and parameters: alternate in_valid 1/0 → out_valid follows the same pattern delayed 4 cycles. Repeat the carry and streaming scenarios with WIDTH=32/SEG=8 and WIDTH=8/SEG=8 (STAGES=1, latency 1).

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into SEG-bit
// segments with one register stage each, under a single valid/ready handshake.
module pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / SEG;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Handshake: a beat moves on any edge where valid && ready. The whole pipe
    // advances unless the output holds a result the consumer has not taken.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign b_eff = op[0] ? ~b : b;
    assign c0    = op[1] ? cin : op[0];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int HI_W = WIDTH - k * SEG;
            localparam int LO_W = (k + 1) * SEG;

            logic [HI_W-1:0] a_in, b_in;
            logic            c_in, v_in;
            logic [SEG:0]    slice;
            logic [LO_W-1:0] r_d, r_q;
            logic            c_q, v_q;

            // Stage k sees the untouched upper operand bits and the finished lower result bits.
            if (k == 0) begin : g_src
                assign a_in = a;
                assign b_in = b_eff;
                assign c_in = c0;
                assign v_in = in_valid;
                assign r_d  = slice[SEG-1:0];
            end else begin : g_src
                assign a_in = g_stage[k-1].g_skew.a_q;
                assign b_in = g_stage[k-1].g_skew.b_q;
                assign c_in = g_stage[k-1].c_q;
                assign v_in = g_stage[k-1].v_q;
                assign r_d  = {slice[SEG-1:0], g_stage[k-1].r_q};
            end

            assign slice = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

            // Data only loads with a valid beat, so the output stage holds through bubbles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= v_in;
                    if (v_in) begin
                        r_q <= r_d;
                        c_q <= slice[SEG];
                    end
                end
            end

            if (k < STAGES - 1) begin : g_skew
                logic [HI_W-SEG-1:0] a_q, b_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (advance && v_in) begin
                        a_q <= a_in[HI_W-1:SEG];
                        b_q <= b_in[HI_W-1:SEG];
                    end
                end
            end
        end
    endgenerate

    // The last stage still holds the operand MSBs, so overflow is resolved there.
    assign ovf_d  = (g_stage[STAGES-1].a_in[SEG-1] == g_stage[STAGES-1].b_in[SEG-1]) &&
                    (g_stage[STAGES-1].r_d[WIDTH-1] != g_stage[STAGES-1].a_in[SEG-1]);
    assign zero_d = ~|g_stage[STAGES-1].r_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance && g_stage[STAGES-1].v_in) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].r_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
